// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_pkg
// Brief   : Shared encodings and helpers for the IF/DM memory-port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arbState_t;

    localparam logic ARB_OWN_IF = 1'b0;
    localparam logic ARB_OWN_DM = 1'b1;

    localparam int STREAK_W = 4;
    localparam int TIMER_W  = 8;

    function automatic logic [STREAK_W-1:0] satInc(
        input logic [STREAK_W-1:0] value,
        input logic [STREAK_W-1:0] limit
    );
        return (value >= limit) ? limit : value + STREAK_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_timer.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_timer
// Brief   : Access timeout counter; expired flags the last allowed BUSY cycle.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arb_timer
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam logic [TIMER_W-1:0] c_lastCount = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] r_count;

    // Holds at the last count so a stalled FSM never wraps back to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (en && (r_count != c_lastCount)) begin
            r_count <= r_count + TIMER_W'(1);
        end
    end

    assign expired = en && (r_count == c_lastCount);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : IF/DM arbiter for one ack-based external memory port, DM priority
//           with a bounded DM streak and a per-access timeout.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4,
    parameter int TIMEOUT       = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_valid,
    output logic              dm_err,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              ext_req,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_ack,
    input  logic [DATA_W-1:0] ext_rdata
);

    localparam logic [STREAK_W-1:0] c_maxStreak = STREAK_W'(MAX_DM_STREAK);

    arbState_t           r_state;
    arbState_t           w_stateNext;
    logic                r_owner;
    logic [STREAK_W-1:0] r_streak;
    logic                w_grant;
    logic                w_grantDm;
    logic                w_finish;
    logic                w_expired;
    logic                w_timerEn;
    logic [DATA_W-1:0]   w_capData;
    logic                w_timedOut;

    logic                r_extReq;
    logic                r_extWe;
    logic [ADDR_W-1:0]   r_extAddr;
    logic [DATA_W-1:0]   r_extWdata;
    logic                r_ifValid;
    logic                r_ifErr;
    logic [DATA_W-1:0]   r_ifRdata;
    logic                r_dmValid;
    logic                r_dmErr;
    logic [DATA_W-1:0]   r_dmRdata;

    always_comb begin
        w_stateNext = r_state;
        w_grant     = 1'b0;
        w_grantDm   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (if_req || dm_req) begin
                    w_grant     = 1'b1;
                    w_grantDm   = dm_req && !(if_req && (r_streak == c_maxStreak));
                    w_stateNext = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (ext_ack || w_expired) begin
                    w_finish    = 1'b1;
                    w_stateNext = ARB_DONE;
                end
            end
            ARB_DONE: w_stateNext = ARB_IDLE;
            default:  w_stateNext = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    assign w_timerEn  = (r_state == ARB_BUSY);
    // An ack wins over a simultaneous expiry; writes never return data.
    assign w_timedOut = !ext_ack;
    assign w_capData  = (ext_ack && !r_extWe) ? ext_rdata : '0;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_grant),
        .en      (w_timerEn),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner    <= ARB_OWN_IF;
            r_streak   <= '0;
            r_extReq   <= 1'b0;
            r_extWe    <= 1'b0;
            r_extAddr  <= '0;
            r_extWdata <= '0;
            r_ifValid  <= 1'b0;
            r_ifErr    <= 1'b0;
            r_ifRdata  <= '0;
            r_dmValid  <= 1'b0;
            r_dmErr    <= 1'b0;
            r_dmRdata  <= '0;
        end else begin
            r_ifValid <= 1'b0;
            r_ifErr   <= 1'b0;
            r_ifRdata <= '0;
            r_dmValid <= 1'b0;
            r_dmErr   <= 1'b0;
            r_dmRdata <= '0;
            if (w_grant) begin
                r_owner    <= w_grantDm ? ARB_OWN_DM : ARB_OWN_IF;
                r_extReq   <= 1'b1;
                r_extWe    <= w_grantDm && dm_we;
                r_extAddr  <= w_grantDm ? dm_addr : if_addr;
                r_extWdata <= w_grantDm ? dm_wdata : '0;
                r_streak   <= (w_grantDm && if_req) ? satInc(r_streak, c_maxStreak) : '0;
            end
            if (w_finish) begin
                r_extReq <= 1'b0;
                if (r_owner == ARB_OWN_DM) begin
                    r_dmValid <= 1'b1;
                    r_dmErr   <= w_timedOut;
                    r_dmRdata <= w_capData;
                end else begin
                    r_ifValid <= 1'b1;
                    r_ifErr   <= w_timedOut;
                    r_ifRdata <= w_capData;
                end
            end
        end
    end

    assign ext_req   = r_extReq;
    assign ext_we    = r_extWe;
    assign ext_addr  = r_extAddr;
    assign ext_wdata = r_extWdata;

    assign if_valid  = r_ifValid;
    assign if_err    = r_ifErr;
    assign if_rdata  = r_ifRdata;
    assign dm_valid  = r_dmValid;
    assign dm_err    = r_dmErr;
    assign dm_rdata  = r_dmRdata;

    assign if_stall  = if_req & ~r_ifValid;
    assign dm_stall  = dm_req & ~r_dmValid;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Scoreboard bench for mem_arbiter with a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TMO  = 8;
    localparam int NC   = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_valid, if_err, if_stall;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_valid, dm_err, dm_stall;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          ext_req, ext_we, ext_ack;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_DM_STREAK(MAXS), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .if_err(if_err), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_valid(dm_valid), .dm_err(dm_err), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata)
    );

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } req_t;
    typedef struct { logic isDm; logic [31:0] data; logic err; } resp_t;

    req_t        extQ[$];
    resp_t       respQ[$];
    logic [31:0] ifPlan[$];
    req_t        dmPlan[$];
    int          latQ[$];
    logic        seenOwner[$];
    bit          expReq[NC], expStart[NC], expVI[NC], expVD[NC], ackPlan[NC];

    int   n = 0, errors = 0, checks = 0;
    int   freeAt = 1, streak = 0, lastGrant = -1, ifDone = -1, dmDone = -1;
    bit   ifPend = 0, dmPend = 0, randomMode = 0, spurNext = 0;
    logic [31:0] ifA = '0;
    req_t dmR;

    function automatic logic [31:0] memData(input logic [31:0] a);
        if (a == 32'h10) return 32'h30F40001;
        return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, n, act, exp);
        end
    endtask

    // Predicts one whole access from the arbitration rules at the grant cycle.
    task automatic grant();
        bit    dmWin;
        req_t  r;
        resp_t rr;
        int    lat, e;
        dmWin = dmPend && !(ifPend && streak == MAXS);
        if (dmWin && ifPend) streak = (streak < MAXS) ? streak + 1 : MAXS;
        else streak = 0;
        if (dmWin) r = dmR;
        else begin r.addr = ifA; r.we = 1'b0; r.wdata = '0; end
        if (latQ.size() > 0) lat = latQ.pop_front();
        else lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
        e = (lat == 0) ? n + TMO : n + lat;
        if (lat != 0) ackPlan[e] = 1;
        for (int c = n + 1; c <= e; c++) expReq[c] = 1;
        expStart[n+1] = 1;
        if (dmWin) begin expVD[e+1] = 1; dmDone = e + 1; end
        else begin expVI[e+1] = 1; ifDone = e + 1; end
        freeAt    = e + 2;
        lastGrant = n;
        extQ.push_back(r);
        rr.isDm = dmWin;
        rr.data = (lat == 0 || r.we) ? 32'h0 : memData(r.addr);
        rr.err  = (lat == 0);
        respQ.push_back(rr);
    endtask

    task automatic cycleStep();
        req_t t;
        @(posedge clk); #1;
        n++;
        rst = 1'b1;
        if (ifPend && ifDone == n) ifPend = 0;
        if (dmPend && dmDone == n) dmPend = 0;
        if (randomMode) begin
            if (!ifPend && ifPlan.size() == 0 && $urandom_range(0, 99) < 40) ifPlan.push_back($urandom);
            if (!dmPend && dmPlan.size() == 0 && $urandom_range(0, 99) < 40) begin
                t.addr = $urandom; t.we = 1'($urandom); t.wdata = $urandom;
                dmPlan.push_back(t);
            end
        end
        if (!ifPend && ifPlan.size() > 0) begin ifA = ifPlan.pop_front(); ifPend = 1; ifDone = -1; end
        if (!dmPend && dmPlan.size() > 0) begin dmR = dmPlan.pop_front(); dmPend = 1; dmDone = -1; end
        if (n >= freeAt && (ifPend || dmPend)) grant();
        if_req = ifPend; if_addr = ifA;
        dm_req = dmPend; dm_we = dmR.we; dm_addr = dmR.addr; dm_wdata = dmR.wdata;
        ext_ack = 1'b0; ext_rdata = $urandom;
        if (ackPlan[n]) begin
            ext_ack   = 1'b1;
            ext_rdata = ext_we ? $urandom : memData(ext_addr);
        end else if (!expReq[n] && (spurNext || (randomMode && $urandom_range(0, 7) == 0))) begin
            ext_ack  = 1'b1;
            spurNext = 0;
        end
    endtask

    task automatic runUntilIdle(input int budget);
        int k = 0;
        while (!(n >= freeAt && !ifPend && !dmPend && ifPlan.size() == 0 && dmPlan.size() == 0)
               && k < budget) begin
            cycleStep();
            k++;
        end
        if (!(n >= freeAt && !ifPend && !dmPend)) begin
            checks++; errors++;
            $display("FAIL drain cycle=%0d got=busy expected=idle within %0d cycles", n, budget);
        end
    endtask

    always @(negedge clk) begin : monitor
        req_t  e;
        resp_t r;
        chk("ext_req", 32'(ext_req), 32'(expReq[n]));
        chk("if_valid", 32'(if_valid), 32'(expVI[n]));
        chk("dm_valid", 32'(dm_valid), 32'(expVD[n]));
        chk("if_stall", 32'(if_stall), 32'(if_req & ~expVI[n]));
        chk("dm_stall", 32'(dm_stall), 32'(dm_req & ~expVD[n]));
        if (expStart[n]) begin
            if (extQ.size() == 0) begin
                checks++; errors++;
                $display("FAIL ext_start cycle=%0d got=none expected=queued request", n);
            end else begin
                e = extQ.pop_front();
                chk("ext_addr", ext_addr, e.addr);
                chk("ext_we", 32'(ext_we), 32'(e.we));
                if (e.we) chk("ext_wdata", ext_wdata, e.wdata);
            end
        end
        if (expVI[n] || expVD[n]) begin
            if (respQ.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp cycle=%0d got=none expected=queued response", n);
            end else begin
                r = respQ.pop_front();
                if (r.isDm) begin
                    chk("dm_rdata", dm_rdata, r.data);
                    chk("dm_err", 32'(dm_err), 32'(r.err));
                end else begin
                    chk("if_rdata", if_rdata, r.data);
                    chk("if_err", 32'(if_err), 32'(r.err));
                end
            end
        end
        if (dm_valid) seenOwner.push_back(1'b1);
        else if (if_valid) seenOwner.push_back(1'b0);
    end

    initial begin
        logic [31:0] seq;
        req_t        t;
        rst = 1'b0; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        ext_ack = 0; ext_rdata = '0;
        dmR.addr = '0; dmR.we = 1'b0; dmR.wdata = '0;

        // single IF read, ack three cycles after the grant
        ifPlan.push_back(32'h10); latQ.push_back(3);
        runUntilIdle(30);

        // DM write, single-cycle ack
        t.addr = 32'h100; t.we = 1'b1; t.wdata = 32'hDEADBEEF;
        dmPlan.push_back(t); latQ.push_back(1);
        runUntilIdle(30);

        // both requesters continuous: streak limit lets IF in every fifth grant
        seenOwner.delete();
        repeat (3) ifPlan.push_back($urandom);
        repeat (8) begin
            t.addr = $urandom; t.we = 1'($urandom); t.wdata = $urandom;
            dmPlan.push_back(t);
        end
        repeat (11) latQ.push_back(1);
        runUntilIdle(100);
        seq = '0;
        for (int i = 0; i < 10; i++) seq[i] = (seenOwner.size() > i) ? seenOwner[i] : 1'bx;
        chk("grant_order", seq, 32'h1EF);

        // no ack: timeout
        t.addr = 32'h200; t.we = 1'b0; t.wdata = '0;
        dmPlan.push_back(t); latQ.push_back(0);
        runUntilIdle(40);

        // stray ack while idle
        spurNext = 1;
        repeat (4) cycleStep();

        // reset in the middle of a BUSY access
        lastGrant = -1;
        ifPlan.push_back(32'h40); latQ.push_back(0);
        for (int k = 0; k < 20 && !(lastGrant >= 0 && n == lastGrant + 2); k++) cycleStep();
        chk("reached_busy", 32'(n), 32'(lastGrant + 2));
        @(posedge clk); #1;
        n++;
        rst = 1'b0; if_req = 0; dm_req = 0; ext_ack = 0;
        ifPend = 0; dmPend = 0; streak = 0; freeAt = n + 1;
        for (int c = n; c < NC; c++) begin
            expReq[c] = 0; expStart[c] = 0; expVI[c] = 0; expVD[c] = 0; ackPlan[c] = 0;
        end
        extQ.delete(); respQ.delete();
        #1;
        chk("async_ext_req", 32'(ext_req), 32'h0);
        ifPlan.push_back(32'h10); latQ.push_back(2);
        runUntilIdle(30);

        // randomized traffic with stray acks and occasional timeouts
        randomMode = 1;
        repeat (1500) cycleStep();
        randomMode = 0;
        runUntilIdle(200);
        repeat (2) cycleStep();
        chk("resp_leftover", 32'(respQ.size()), 32'h0);
        chk("ext_leftover", 32'(extQ.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the Y86 core's single external memory port. Instruction fetch (IF) and the memory stage (DM) share the port, which has a variable-latency, acknowledge-based handshake. DM normally has priority, with a streak limit so fetch cannot starve. The block sits between the pipeline's fetch/memory stages and the external memory. It returns registered responses and per-requester stall signals that the pipeline registers use to freeze.

## Interface
Parameters:
- ADDR_W, 32, address width (matches the `WORD` width).
- DATA_W, 32, data width (matches the `WORD` width).
- MAX_DM_STREAK, 4, number of consecutive DM grants allowed while IF waits; range 1..15.
- TIMEOUT, 64, number of BUSY cycles without ext_ack before the access is aborted; range 2..255.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- if_req  in  1  fetch read request; level, held until if_valid.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_valid  out  1  one-cycle response pulse to fetch.
- if_rdata  out  DATA_W  fetch read data; valid with if_valid.
- if_err  out  1  fetch access timed out; valid with if_valid.
- if_stall  out  1  high while if_req is high and if_valid is low.
- dm_req, dm_we  in  1 each  data request and write enable; held until dm_valid.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  data write value.
- dm_valid, dm_err  out  1 each  data response pulse and timeout flag.
- dm_rdata  out  DATA_W  data read data; 0 for writes.
- dm_stall  out  1  high while dm_req is high and dm_valid is low.
- ext_req, ext_we  out  1 each  external request and write enable.
- ext_addr  out  ADDR_W  external address.
- ext_wdata  out  DATA_W  external write data.
- ext_ack  in  1  one-cycle acknowledge from the memory.
- ext_rdata  in  DATA_W  external read data; valid in the ext_ack cycle.

## Operation
- State machine states: IDLE, BUSY, DONE. A 1-bit `owner` register records the current requester (0 = IF, 1 = DM).
- IDLE:
  - If any request is present, latch the winner's addr/we/wdata into the ext_* registers, set ext_req=1 and go to BUSY.
  - IF requests are always reads; ext_we=0 for IF.
- Arbitration when both requesters are present: DM wins, unless `streak` == MAX_DM_STREAK, in which case IF wins.
- The `streak` counter (4 bits):
  - +1 on a DM grant while if_req=1.
  - Cleared on an IF grant.
  - Cleared on a DM grant while if_req=0.
  - Saturates at MAX_DM_STREAK.
- BUSY:
  - ext_* outputs hold steady.
  - On ext_ack=1: capture ext_rdata (0 for writes), drop ext_req, go to DONE.
  - If the timeout counter reaches TIMEOUT-1 with no ack: drop ext_req, set the error flag, force captured data to 0, go to DONE.
- DONE:
  - Pulse the owner's valid/rdata/err for exactly one cycle.
  - No arbitration in DONE; return to IDLE.
  - The requester must drop or change its req in the cycle it sees valid.
- An ext_ack outside BUSY is ignored.
- Reset, asynchronous, including mid-transaction:
  - State returns to IDLE; streak, timer and owner are cleared.
  - All outputs go to 0 immediately: ext_req=0, valid=0, err=0, rdata=0.
  - Stall outputs are combinational from the req inputs, so they follow if_req/dm_req.
  - The external memory must tolerate an abandoned request.

## Timing
- Cycle 0: a request is sampled in IDLE.
- Cycle 1: ext_req=1 with registered addr/we/wdata.
- Cycle k ≥ 1: ext_ack=1.
- Cycle k+1: the owner's valid pulse. Back in IDLE at k+2.
- Minimum turnaround is 3 cycles per access (ack in cycle 1). Maximum is TIMEOUT+2 cycles.
- A requester losing arbitration waits at least one full transaction.
- Both stall outputs are combinational: stall = req & ~valid.

## Structure
- Add to the shared defines file:
  - State encodings `ARB_IDLE`, `ARB_BUSY`, `ARB_DONE` (2-bit).
  - Owner codes `ARB_OWN_IF`, `ARB_OWN_DM`.
- One sub-module, `mem_arb_timer`: an 8-bit timeout counter with ports clk, rst, clear, en, expired. It is cleared on entry to BUSY and enabled while in BUSY.
- Expected RTL size is about 200 lines.

## Test plan
- Single IF read, addr=0x10, ack in cycle 3 with rdata=0x30F40001 → ext_req high in cycles 1–3, if_valid=1 with if_rdata=0x30F40001 in cycle 4, if_stall low from cycle 4.
- DM write, addr=0x100, wdata=0xDEADBEEF, ack in cycle 1 → ext_we=1 and ext_wdata=0xDEADBEEF in cycle 1, dm_valid with dm_rdata=0 in cycle 2.
- IF and DM both request continuously, MAX_DM_STREAK=4, 1-cycle acks → grant sequence DM,DM,DM,DM,IF,DM,DM,DM,DM,IF.
- No ack, TIMEOUT=8 → ext_req drops after 8 BUSY cycles, then valid=1, err=1, rdata=0, then IDLE.
- rst driven to 0 mid-BUSY → ext_req=0 asynchronously, same cycle; after release, a fresh IF read completes normally.
- ext_ack pulsed while in IDLE → ignored: no valid pulse and no state change.
